// File: rtl/usb_protocol_pkg.sv
// Shared USB FIFO protocol definitions: command codes, byte layout and the
// state encodings used by the transmit path.
package usb_protocol_pkg;

    // FPGA-to-PC panel report commands
    localparam logic [3:0] CMD_PANEL0 = 4'd1;
    localparam logic [3:0] CMD_PANEL1 = 4'd2;
    localparam logic [3:0] CMD_PANEL2 = 4'd3;
    localparam logic [3:0] CMD_PANEL3 = 4'd4;

    // PC-to-FPGA panel selector request
    localparam logic [3:0] CMD_REQ_PANEL_SEL = 4'd1;

    typedef enum logic [2:0] {
        TX_IDLE,
        TX_WAIT,
        TX_SETUP,
        TX_STROBE,
        TX_HOLD
    } tx_state_t;

    typedef enum logic [1:0] {
        SEQ_IDLE,
        SEQ_WAIT,
        SEQ_SEND
    } seq_state_t;

    typedef struct packed {
        logic [3:0] cmd;
        logic [3:0] payload;
    } usb_byte_t;

    function automatic logic [3:0] panel_cmd(input logic [1:0] idx);
        return CMD_PANEL0 + {2'b00, idx};
    endfunction

endpackage

// File: rtl/usb_write_strobe.sv
// Single-byte FT245 write cycle: SETUP (data driven, wr_n high), STROBE
// (wr_n low), HOLD (wr_n high, data still driven). ack pulses on the last HOLD cycle.
module usb_write_strobe
    import usb_protocol_pkg::*;
#(
    parameter int SETUP_CYCLES  = 1,
    parameter int STROBE_CYCLES = 2,
    parameter int HOLD_CYCLES   = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [7:0] byte_in,
    output logic       ack,
    output logic [7:0] data_out,
    output logic       data_oe,
    output logic       wr_n
);

    localparam int MAX_SS     = (SETUP_CYCLES > STROBE_CYCLES) ? SETUP_CYCLES : STROBE_CYCLES;
    localparam int MAX_CYCLES = (MAX_SS > HOLD_CYCLES) ? MAX_SS : HOLD_CYCLES;
    localparam int PHASE_W    = $clog2(MAX_CYCLES) + 1;

    localparam logic [PHASE_W-1:0] SETUP_LAST  = PHASE_W'(SETUP_CYCLES - 1);
    localparam logic [PHASE_W-1:0] STROBE_LAST = PHASE_W'(STROBE_CYCLES - 1);
    localparam logic [PHASE_W-1:0] HOLD_LAST   = PHASE_W'(HOLD_CYCLES - 1);

    tx_state_t            state_reg, state_next;
    logic [PHASE_W-1:0]   phase_reg, phase_next;
    logic [7:0]           data_reg, data_next;
    logic                 oe_reg, oe_next;
    logic                 wr_n_reg, wr_n_next;

    always_comb begin
        state_next = state_reg;
        ack        = 1'b0;
        case (state_reg)
            TX_SETUP:  if (phase_reg == SETUP_LAST)  state_next = TX_STROBE;
            TX_STROBE: if (phase_reg == STROBE_LAST) state_next = TX_HOLD;
            TX_HOLD: begin
                if (phase_reg == HOLD_LAST) begin
                    state_next = TX_IDLE;
                    ack        = 1'b1;
                end
            end
            default:   if (start) state_next = TX_SETUP;
        endcase

        // One shared phase counter, reloaded on every state change
        if (state_next != state_reg || state_reg == TX_IDLE)
            phase_next = '0;
        else
            phase_next = phase_reg + 1'b1;

        data_next = data_reg;
        if (state_reg == TX_IDLE && start)
            data_next = byte_in;
        else if (state_next == TX_IDLE)
            data_next = '0;

        oe_next   = (state_next == TX_SETUP) || (state_next == TX_STROBE) || (state_next == TX_HOLD);
        wr_n_next = (state_next != TX_STROBE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg <= TX_IDLE;
            phase_reg <= '0;
            data_reg  <= '0;
            oe_reg    <= 1'b0;
            wr_n_reg  <= 1'b1;
        end else begin
            state_reg <= state_next;
            phase_reg <= phase_next;
            data_reg  <= data_next;
            oe_reg    <= oe_next;
            wr_n_reg  <= wr_n_next;
        end
    end

    assign data_out = data_reg;
    assign data_oe  = oe_reg;
    assign wr_n     = wr_n_reg;

endmodule

// File: rtl/usb_tx_reporter.sv
// Panel report transmitter: snapshots the switches on request and sends one
// {cmd, nibble} byte per panel through usb_write_strobe, keeping one pending request.
module usb_tx_reporter
    import usb_protocol_pkg::*;
#(
    parameter int NUM_PANELS    = 4,
    parameter int SETUP_CYCLES  = 1,
    parameter int STROBE_CYCLES = 2,
    parameter int HOLD_CYCLES   = 1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    request,
    input  logic [4*NUM_PANELS-1:0] panel_switches,
    input  logic                    txe_n,
    input  logic                    bus_free,
    output logic [7:0]              data_out,
    output logic                    data_oe,
    output logic                    wr_n,
    output logic                    busy,
    output logic                    done
);

    localparam logic [1:0] LAST_INDEX = 2'(NUM_PANELS - 1);

    seq_state_t              seq_reg, seq_next;
    logic [1:0]              index_reg, index_next;
    logic [4*NUM_PANELS-1:0] snap_reg, snap_next;
    logic                    pending_reg, pending_next;
    logic                    busy_reg, busy_next;
    logic                    done_reg, done_next;
    logic                    start;
    logic                    ack;
    logic [3:0]              nibble [4];
    usb_byte_t               tx_byte;

    // Unused panel slots read as zero so the index never selects out of range
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_nibble
            if (gi < NUM_PANELS) begin : g_used
                assign nibble[gi] = snap_reg[4*gi +: 4];
            end else begin : g_unused
                assign nibble[gi] = 4'd0;
            end
        end
    endgenerate

    assign tx_byte.cmd     = panel_cmd(index_reg);
    assign tx_byte.payload = nibble[index_reg];

    always_comb begin
        seq_next     = seq_reg;
        index_next   = index_reg;
        snap_next    = snap_reg;
        pending_next = pending_reg;
        busy_next    = busy_reg;
        done_next    = 1'b0;
        start        = 1'b0;
        case (seq_reg)
            SEQ_IDLE: begin
                if (request || pending_reg) begin
                    snap_next    = panel_switches;
                    index_next   = 2'd0;
                    pending_next = 1'b0;
                    busy_next    = 1'b1;
                    seq_next     = SEQ_WAIT;
                end
            end
            SEQ_WAIT: begin
                if (request) pending_next = 1'b1;
                if (!txe_n && bus_free) begin
                    start    = 1'b1;
                    seq_next = SEQ_SEND;
                end
            end
            SEQ_SEND: begin
                if (request) pending_next = 1'b1;
                if (ack) begin
                    if (index_reg == LAST_INDEX) begin
                        seq_next  = SEQ_IDLE;
                        busy_next = 1'b0;
                        done_next = 1'b1;
                    end else begin
                        index_next = index_reg + 2'd1;
                        seq_next   = SEQ_WAIT;
                    end
                end
            end
            default: seq_next = SEQ_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            seq_reg     <= SEQ_IDLE;
            index_reg   <= 2'd0;
            snap_reg    <= '0;
            pending_reg <= 1'b0;
            busy_reg    <= 1'b0;
            done_reg    <= 1'b0;
        end else begin
            seq_reg     <= seq_next;
            index_reg   <= index_next;
            snap_reg    <= snap_next;
            pending_reg <= pending_next;
            busy_reg    <= busy_next;
            done_reg    <= done_next;
        end
    end

    usb_write_strobe #(
        .SETUP_CYCLES (SETUP_CYCLES),
        .STROBE_CYCLES(STROBE_CYCLES),
        .HOLD_CYCLES  (HOLD_CYCLES)
    ) u_strobe (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .byte_in (tx_byte),
        .ack     (ack),
        .data_out(data_out),
        .data_oe (data_oe),
        .wr_n    (wr_n)
    );

    assign busy = busy_reg;
    assign done = done_reg;

endmodule

// File: tb/tb_usb_tx_reporter.sv
// Scoreboard bench for usb_tx_reporter: a transaction-level model predicts the
// byte stream and busy/done/bus timing; a monitor compares every cycle.
module tb_usb_tx_reporter;

    localparam int NP    = 4;
    localparam int S     = 1;
    localparam int ST    = 2;
    localparam int H     = 1;
    localparam int TOTAL = S + ST + H;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        request = 1'b0;
    logic [15:0] panel_switches = 16'hA5C3;
    logic        txe_n = 1'b0;
    logic        bus_free = 1'b1;
    logic [7:0]  data_out;
    logic        data_oe, wr_n, busy, done;
    logic [7:0]  d1_data;
    logic        d1_oe, d1_wr_n, d1_busy, d1_done;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    usb_tx_reporter #(.NUM_PANELS(NP), .SETUP_CYCLES(S), .STROBE_CYCLES(ST), .HOLD_CYCLES(H)) u_dut (
        .clk(clk), .reset(rst), .request(request), .panel_switches(panel_switches),
        .txe_n(txe_n), .bus_free(bus_free), .data_out(data_out), .data_oe(data_oe),
        .wr_n(wr_n), .busy(busy), .done(done)
    );

    usb_tx_reporter #(.NUM_PANELS(1)) u_dut1 (
        .clk(clk), .reset(rst), .request(request), .panel_switches(panel_switches[3:0]),
        .txe_n(txe_n), .bus_free(bus_free), .data_out(d1_data), .data_oe(d1_oe),
        .wr_n(d1_wr_n), .busy(d1_busy), .done(d1_done)
    );

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // Reference model: report-level bookkeeping with a per-byte countdown
    logic [7:0] exp_q[$];
    logic [7:0] q1[$];
    bit m_active, m_pending, m_waiting, m_done;
    int m_byte, m_timer;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_active = 0; m_pending = 0; m_waiting = 0; m_done = 0;
            m_byte = 0; m_timer = 0;
            exp_q.delete();
        end else begin
            m_done = 0;
            if (!m_active) begin
                if (request || m_pending) begin
                    for (int p = 0; p < NP; p++)
                        exp_q.push_back({4'(p + 1), panel_switches[4*p +: 4]});
                    m_active = 1; m_byte = 0; m_waiting = 1; m_pending = 0;
                end
            end else begin
                if (request) m_pending = 1;
                if (m_waiting) begin
                    if (!txe_n && bus_free) begin
                        m_waiting = 0;
                        m_timer = TOTAL;
                    end
                end else begin
                    m_timer--;
                    if (m_timer == 0) begin
                        if (m_byte == NP - 1) begin
                            m_active = 0;
                            m_done = 1;
                        end else begin
                            m_byte++;
                            m_waiting = 1;
                        end
                    end
                end
            end
        end
    end

    // Monitor: per-cycle handshake/bus checks plus byte scoreboard at wr_n rise
    logic prev_wr_n = 1'b1;
    logic d1_prev = 1'b1;
    always @(negedge clk) begin
        bit exp_oe, exp_wr;
        int pos;
        if (rst) begin
            prev_wr_n = 1'b1;
            d1_prev = 1'b1;
        end else begin
            check("busy", busy, m_active);
            check("done", done, m_done);
            exp_oe = m_active && !m_waiting;
            pos = TOTAL - m_timer;
            exp_wr = !(exp_oe && pos >= S && pos < S + ST);
            check("bus_oe_wr", {data_oe, wr_n}, {exp_oe, exp_wr});
            if (!prev_wr_n && wr_n) begin
                if (exp_q.size() == 0) begin
                    tests++; fails++;
                    $display("FAIL byte_extra: got %h expected none", data_out);
                end else begin
                    check("byte", data_out, exp_q.pop_front());
                end
            end
            prev_wr_n = wr_n;
            if (!d1_prev && d1_wr_n) q1.push_back(d1_data);
            d1_prev = d1_wr_n;
        end
    end

    // One directed report: request at cycle 0, optional stalls and extra requests
    task automatic directed(input string name, input int txe_lo, input int txe_hi,
                            input int bf_lo, input int bf_hi, input bit multi,
                            input int done_at, input int n_done, input bit check1);
        logic [7:0] ref_b [4];
        logic [7:0] got[$];
        logic lprev;
        int first, ndone, d1_first;
        ref_b = '{8'h13, 8'h2C, 8'h35, 8'h4A};
        first = -1; ndone = 0; d1_first = -1; lprev = 1'b1;
        panel_switches = 16'hA5C3;
        q1.delete();
        for (int c = 0; c < 60; c++) begin
            @(posedge clk); #1;
            request  = (c == 0) || (multi && (c == 3 || c == 8 || c == 12));
            txe_n    = (c >= txe_lo && c <= txe_hi);
            bus_free = !(c >= bf_lo && c <= bf_hi);
            if (c == 3) panel_switches = 16'hFFFF;
            @(negedge clk);
            if (done) begin
                if (first < 0) first = c;
                ndone++;
            end
            if (d1_done && d1_first < 0) d1_first = c;
            if (!lprev && wr_n) got.push_back(data_out);
            lprev = wr_n;
        end
        check({name, "_done_cycle"}, first, done_at);
        check({name, "_done_count"}, ndone, n_done);
        check({name, "_byte_count"}, got.size(), 4 * n_done);
        for (int i = 0; i < 4; i++)
            if (i < got.size()) check({name, "_byte"}, got[i], ref_b[i]);
        if (check1) begin
            check("np1_byte_count", q1.size(), 1);
            if (q1.size() > 0) check("np1_byte", q1[0], 8'h13);
            check("np1_done_cycle", d1_first, 6);
        end
        request = 0; txe_n = 0; bus_free = 1; panel_switches = 16'hA5C3;
    endtask

    initial begin
        int waited;
        #2 rst = 1'b1;
        #20;
        check("rst_outputs", {data_out, data_oe, wr_n, busy, done}, {8'h00, 1'b0, 1'b1, 1'b0, 1'b0});
        @(negedge clk); rst = 1'b0;
        repeat (3) @(posedge clk);

        directed("base",  -1, -1, -1, -1, 0, 21, 1, 1);
        directed("txe",   11, 17, -1, -1, 0, 28, 1, 0);
        directed("busf",   5,  5,  1,  4, 0, 26, 1, 0);
        directed("multi", -1, -1, -1, -1, 1, 21, 2, 0);

        // Randomized traffic
        for (int c = 0; c < 3000; c++) begin
            @(posedge clk); #1;
            request        = ($urandom_range(0, 9) == 0);
            txe_n          = ($urandom_range(0, 3) == 0);
            bus_free       = ($urandom_range(0, 4) != 0);
            panel_switches = 16'($urandom);
        end
        @(posedge clk); #1;
        request = 0; txe_n = 0; bus_free = 1;
        repeat (100) @(posedge clk);

        // Asynchronous reset in the middle of a strobe
        @(posedge clk); #1; request = 1;
        @(posedge clk); #1; request = 0;
        waited = 0;
        while (wr_n && waited < 30) begin
            @(negedge clk);
            waited++;
        end
        check("strobe_reached", {31'd0, wr_n}, 32'd0);
        @(posedge clk); #2 rst = 1'b1;
        #1;
        check("rst_mid_strobe", {data_oe, wr_n, busy}, {1'b0, 1'b1, 1'b0});
        repeat (2) @(posedge clk);
        #2 rst = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        check("idle_after_rst", {data_oe, wr_n, busy}, {1'b0, 1'b1, 1'b0});

        repeat (5) @(posedge clk);
        check("scoreboard_empty", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/usb_tx_reporter.md
Name: usb_tx_reporter

Overview:
FPGA-to-PC transmit engine for the FT245-style USB FIFO interface. On a panel-selector request it snapshots the synchronized panel switches and sends the four report bytes {cmd, nibble}: cmd 1..4 carry panel_switches[3:0], [7:4], [11:8], [15:12] in that order. It sits beside the receive path inside the USB controller. It owns wr_n and the data-bus output enable, and holds busy high so the receive sequencer does not issue reads while the bus is driven.

Parameters:
NUM_PANELS, 4, number of report bytes per request; panel p uses cmd p+1 and switches [4p+3:4p]. Legal range 1..4.
SETUP_CYCLES, 1, cycles data is driven with wr_n high before the strobe; >=1.
STROBE_CYCLES, 2, cycles wr_n is held low; >=1.
HOLD_CYCLES, 1, cycles data stays driven after wr_n rises; >=1.

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
request  in  1  single-cycle pulse: send a panel report
panel_switches  in  4*NUM_PANELS  already-synchronized switch values
txe_n  in  1  already-synchronized FIFO "space available", active low
bus_free  in  1  receive path idle (no read cycle in progress)
data_out  out  8  byte to drive onto the FIFO data bus
data_oe  out  1  tri-state enable for data_out
wr_n  out  1  FIFO write strobe, active low; FIFO latches data on the rising edge
busy  out  1  report in progress; receive path must not start reads
done  out  1  single-cycle pulse after the last byte completes

Behaviour:
- Reset (async, any state): state IDLE; wr_n=1, data_oe=0, data_out=0, busy=0, done=0; pending flag cleared; byte index cleared. Bus is released immediately, even mid-strobe.
- All outputs are registered.
- States: IDLE, WAIT, SETUP, STROBE, HOLD.
  - IDLE: if request or pending is set, snapshot panel_switches, set byte index=0, clear pending, go to WAIT. busy=1 from the next cycle.
  - WAIT: data_oe=0, wr_n=1. Go to SETUP only when txe_n==0 and bus_free==1 in the same cycle; otherwise stay, with no timeout.
  - SETUP: data_oe=1, data_out={cmd(index+1), snapshot nibble[index]}, wr_n=1, for SETUP_CYCLES, then go to STROBE.
  - STROBE: wr_n=0 and data held, for STROBE_CYCLES, then go to HOLD.
  - HOLD: wr_n=1 and data held, for HOLD_CYCLES. Then, if index<NUM_PANELS-1: increment index and go to WAIT. Otherwise go to IDLE with done=1 for that first IDLE cycle, and busy=0 in the same cycle.
- txe_n rising during SETUP, STROBE or HOLD: the current byte completes its full cycle. txe_n is only re-checked in WAIT.
- bus_free falling after WAIT: ignored for the current byte.
- Request handling:
  - A request while busy sets pending; only one pending request is kept and extra requests are dropped.
  - Pending starts a new report from IDLE on the cycle after done, with a fresh snapshot.
  - A request in the same cycle as done also becomes pending.
- Snapshot: panel_switches changes after acceptance do not affect the current report.
- Counters: a single phase counter of width clog2(max(SETUP,STROBE,HOLD))+1, reloaded on every state change. The byte index is 2 bits and never wraps mid-report.
- Latency with defaults, request at cycle 0 and the FIFO always ready:
  - byte k is in WAIT at cycle 1+5k, SETUP at 2+5k, STROBE at 3..4+5k, HOLD at 5+5k;
  - done at cycle 21; busy is high for cycles 1..20.

Decomposition:
- Shared package usb_protocol_pkg:
  - FPGA-to-PC command codes CMD_PANEL0..CMD_PANEL3 = 4'd1..4'd4;
  - PC-to-FPGA code CMD_REQ_PANEL_SEL = 4'd1;
  - tx state enum;
  - byte layout: cmd in [7:4], payload in [3:0].
- One sub-module is natural: usb_write_strobe, a single-byte SETUP/STROBE/HOLD timing engine with a start/ack handshake. usb_tx_reporter sequences the bytes, the snapshot and the pending request around it.

Test Plan:
- panel_switches=16'hA5C3, txe_n=0, bus_free=1, request at cycle 0 -> bytes 0x13, 0x2C, 0x35, 0x4A latched at wr_n rising edges on cycles 5, 10, 15, 20; done at 21; busy high for cycles 1..20.
- txe_n held high for 7 cycles at the start of byte 2 -> bus stays in WAIT with data_oe=0 and wr_n=1; byte 0x35 is sent 7 cycles late; byte order and values unchanged.
- Switches changed to 16'hFFFF at cycle 3 of the report -> all four bytes still carry the A5C3 nibbles.
- Three requests during busy -> exactly one more report (4 bytes) starts the cycle after done; not two.
- Reset asserted during STROBE -> wr_n=1 and data_oe=0 in the same cycle; after release, outputs stay idle until a new request.
- bus_free=0 for 4 cycles at WAIT of byte 0 -> no strobe until bus_free=1 and txe_n=0 together; NUM_PANELS=1 build sends only 0x13, then done.
